icache: RTL

- Direct-mapped instruction cache between the instruction fetcher (downstream consumer) and the memory controller's byte-stream instruction port (upstream).
- Accepts one 32-bit fetch request at a time.
- Hits return one cycle after acceptance. Misses refill a whole line byte-by-byte, then respond.
- A ROB flush aborts any pending request or refill.

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_if.sv | 24 ++
 rtl/icache_line_array.sv | 47 ++++
 rtl/icache.sv | 138 +++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared sizing defaults and the controller state encoding for the instruction cache.
package icache_pkg;

   localparam int DEF_LINE_BYTES = 16;
   localparam int DEF_NUM_LINES  = 32;
   localparam int DEF_OFF_W      = $clog2(DEF_LINE_BYTES);
   localparam int DEF_IDX_W      = $clog2(DEF_NUM_LINES);
   localparam int DEF_TAG_W      = 32 - DEF_IDX_W - DEF_OFF_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_REFILL = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// fetch_valid is a level request held with a stable fetch_addr until the
// one-cycle fetch_ready strobe (or a flush); mc_byte_valid marks one refill byte.
interface icache_if;
   logic        fetch_valid;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic [31:0] fetch_inst;
   logic        flush;
   logic        mc_req;
   logic [31:0] mc_addr;
   logic        mc_byte_valid;
   logic [7:0]  mc_byte;

   modport slave (
      input  fetch_valid, fetch_addr, flush, mc_byte_valid, mc_byte,
      output fetch_ready, fetch_inst, mc_req, mc_addr
   );

   modport master (
      output fetch_valid, fetch_addr, flush, mc_byte_valid, mc_byte,
      input  fetch_ready, fetch_inst, mc_req, mc_addr
   );
endinterface

// File: rtl/icache_line_array.sv
// Tag/valid/data storage: synchronous read, whole-line write, valid bits in flops.
module icache_line_array #(
   parameter int LINE_BYTES = 16,
   parameter int NUM_LINES  = 32,
   parameter int IDX_W      = $clog2(NUM_LINES),
   parameter int TAG_W      = 32 - $clog2(NUM_LINES) - $clog2(LINE_BYTES)
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rd_en,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic                    rd_valid,
   output logic [TAG_W-1:0]        rd_tag,
   output logic [LINE_BYTES*8-1:0] rd_data,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [TAG_W-1:0]        wr_tag,
   input  logic [LINE_BYTES*8-1:0] wr_data
);

   logic [TAG_W-1:0]        tag_mem  [NUM_LINES];
   logic [LINE_BYTES*8-1:0] data_mem [NUM_LINES];
   logic [NUM_LINES-1:0]    valid;

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         valid    <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (wr_en) valid[wr_idx] <= 1'b1;
         if (rd_en) rd_valid <= valid[rd_idx];
      end
   end

   // Storage arrays carry no reset; the valid vector alone qualifies them.
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
      if (rd_en) begin
         rd_tag  <= tag_mem[rd_idx];
         rd_data <= data_mem[rd_idx];
      end
   end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: one-cycle hits, byte-serial line refill, flush abort.
module icache import icache_pkg::*; #(
   parameter int LINE_BYTES = DEF_LINE_BYTES,
   parameter int NUM_LINES  = DEF_NUM_LINES
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rdy_in,
   icache_if.slave    bus,
   output state_t     dbg_state
);

   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = 32 - IDX_W - OFF_W;
   localparam int LINE_W = LINE_BYTES * 8;

   state_t            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [OFF_W-1:0]  cnt_q, cnt_d;
   logic [LINE_W-1:0] line_q, line_d, line_next;
   logic              mc_req_q, mc_req_d;
   logic [31:0]       mc_addr_q, mc_addr_d;

   logic              arr_valid;
   logic [TAG_W-1:0]  arr_tag;
   logic [LINE_W-1:0] arr_data;

   logic              tag_hit, hit, accept, byte_take, last_byte, ready;
   logic [LINE_W-1:0] src_line;
   logic [OFF_W-1:0]  off;
   logic [31:0]       inst_word;

   icache_line_array #(
      .LINE_BYTES(LINE_BYTES),
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_array (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .rd_en   (accept),
      .rd_idx  (bus.fetch_addr[OFF_W +: IDX_W]),
      .rd_valid(arr_valid),
      .rd_tag  (arr_tag),
      .rd_data (arr_data),
      .wr_en   (last_byte),
      .wr_idx  (addr_q[OFF_W +: IDX_W]),
      .wr_tag  (addr_q[31 -: TAG_W]),
      .wr_data (line_next)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         line_q    <= '0;
         mc_req_q  <= 1'b0;
         mc_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         line_q    <= line_d;
         mc_req_q  <= mc_req_d;
         mc_addr_q <= mc_addr_d;
      end
   end

   always_comb begin
      tag_hit   = arr_valid && (arr_tag == addr_q[31 -: TAG_W]);
      hit       = (state_q == ST_LOOKUP) && tag_hit;
      ready     = (hit || state_q == ST_RESP) && rdy_in && !bus.flush;
      accept    = bus.fetch_valid && !bus.flush && rdy_in &&
                  (state_q == ST_IDLE || state_q == ST_RESP || hit);
      byte_take = (state_q == ST_REFILL) && bus.mc_byte_valid && rdy_in && !bus.flush;
      last_byte = byte_take && (cnt_q == OFF_W'(LINE_BYTES - 1));

      // The final byte is merged here so the array write sees the complete line.
      line_next = line_q;
      if (byte_take) line_next[8*int'(cnt_q) +: 8] = bus.mc_byte;

      src_line  = (state_q == ST_RESP) ? line_q : arr_data;
      off       = addr_q[OFF_W-1:0];
      inst_word = src_line[32*(int'(off) >> 2) +: 32];
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      line_d    = line_q;
      mc_req_d  = mc_req_q;
      mc_addr_d = mc_addr_q;
      if (rdy_in) begin
         if (bus.flush) begin
            state_d  = ST_IDLE;
            mc_req_d = 1'b0;
            cnt_d    = '0;
         end else begin
            case (state_q)
               ST_IDLE:   if (accept) state_d = ST_LOOKUP;
               ST_LOOKUP: begin
                  if (tag_hit) begin
                     state_d = accept ? ST_LOOKUP : ST_IDLE;
                  end else begin
                     state_d   = ST_REFILL;
                     mc_req_d  = 1'b1;
                     mc_addr_d = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
                     cnt_d     = '0;
                  end
               end
               ST_REFILL: begin
                  if (byte_take) begin
                     line_d = line_next;
                     cnt_d  = cnt_q + OFF_W'(1);
                     if (last_byte) begin
                        mc_req_d = 1'b0;
                        state_d  = ST_RESP;
                     end
                  end
               end
               ST_RESP:   state_d = accept ? ST_LOOKUP : ST_IDLE;
               default:   state_d = ST_IDLE;
            endcase
            if (accept) addr_d = bus.fetch_addr;
         end
      end
   end

   assign bus.fetch_ready = ready;
   assign bus.fetch_inst  = ready ? inst_word : 32'h0;
   assign bus.mc_req      = mc_req_q;
   assign bus.mc_addr     = mc_addr_q;
   assign dbg_state       = state_q;

endmodule
